// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer arbiter.
// Holds the sequencer state encoding and engine mode codes.
package spi_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_SETUP,
    ARB_LOAD,
    ARB_XFER,
    ARB_HOLD,
    ARB_GAP
  } spi_arb_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  localparam int SPI_SETUP_CYC_DEF = 2;
  localparam int SPI_HOLD_CYC_DEF  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request
// strictly after last_gnt wins, wrapping around.
module rr_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last_gnt,
  input  logic            en,
  output logic [NREQ-1:0] gnt
);

  logic [LW-1:0] idx;

  // Walk from the farthest slot inward so the nearest one overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    if (en) begin
      for (int i = NREQ; i >= 1; i--) begin
        idx = LW'((int'(last_gnt) + i) % NREQ);
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI byte engine among NREQ requesters with
// round-robin grant and SS setup/hold framing.
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NSS       = 4,
  parameter int SETUP_CYC = SPI_SETUP_CYC_DEF,
  parameter int HOLD_CYC  = SPI_HOLD_CYC_DEF,
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ*8-1:0] REQ_LEN,
  input  logic [NREQ*SW-1:0] REQ_SS,
  input  logic [NREQ*2-1:0] REQ_MODE,
  output logic [NREQ-1:0]  GNT,
  input  logic [7:0]       TX_DATA,
  input  logic             TX_VALID,
  output logic             TX_READY,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  output logic             SESS_DONE,
  output logic             ENG_START,
  output logic [7:0]       ENG_TXBYTE,
  output logic [1:0]       ENG_MODE,
  input  logic             ENG_DONE,
  input  logic [7:0]       ENG_RXBYTE,
  output logic [NSS-1:0]   SS_N
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = 16;

  spi_arb_state_t state_q, state_d;

  logic [TW-1:0]   t_q, t_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [LW-1:0]   gidx_q, gidx_d;
  logic [LW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NSS-1:0]  ss_n_q, ss_n_d;
  logic            tx_ready_q, tx_ready_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            sess_done_q, sess_done_d;
  logic            eng_start_q, eng_start_d;
  logic [7:0]      eng_tx_q, eng_tx_d;
  logic [1:0]      eng_mode_q, eng_mode_d;

  logic [NREQ-1:0] arb_gnt;
  logic [LW-1:0]   sel_idx;
  logic [7:0]      sel_len;
  logic [SW-1:0]   sel_ss;
  logic [SW-1:0]   ss_eff;
  logic [1:0]      sel_mode;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req      (REQ),
    .last_gnt (last_q),
    .en       (state_q == ARB_IDLE),
    .gnt      (arb_gnt)
  );

  always_comb begin
    sel_idx  = '0;
    sel_len  = '0;
    sel_ss   = '0;
    sel_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_idx  = LW'(i);
        sel_len  = REQ_LEN[i*8 +: 8];
        sel_ss   = REQ_SS[i*SW +: SW];
        sel_mode = REQ_MODE[i*2 +: 2];
      end
    end
  end

  // Out-of-range slave indices fall back to slave 0.
  assign ss_eff = (int'(sel_ss) >= NSS) ? '0 : sel_ss;

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    cnt_d       = cnt_q;
    gidx_d      = gidx_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    ss_n_d      = ss_n_q;
    tx_ready_d  = tx_ready_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    sess_done_d = 1'b0;
    eng_start_d = 1'b0;
    eng_tx_d    = eng_tx_q;
    eng_mode_d  = eng_mode_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|arb_gnt) begin
          gnt_d          = arb_gnt;
          gidx_d         = sel_idx;
          cnt_d          = sel_len;
          eng_mode_d     = sel_mode;
          ss_n_d         = '1;
          ss_n_d[ss_eff] = 1'b0;
          t_d            = TW'(SETUP_CYC - 1);
          state_d        = ARB_SETUP;
        end
      end
      ARB_SETUP: begin
        if (t_q == '0) begin
          tx_ready_d = 1'b1;
          state_d    = ARB_LOAD;
        end else begin
          t_d = t_q - 1'b1;
        end
      end
      ARB_LOAD: begin
        if (TX_VALID) begin
          eng_tx_d    = TX_DATA;
          eng_start_d = 1'b1;
          tx_ready_d  = 1'b0;
          state_d     = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (ENG_DONE) begin
          rx_data_d  = ENG_RXBYTE;
          rx_valid_d = 1'b1;
          if (cnt_q == '0) begin
            t_d     = TW'(HOLD_CYC - 1);
            state_d = ARB_HOLD;
          end else begin
            cnt_d      = cnt_q - 1'b1;
            tx_ready_d = 1'b1;
            state_d    = ARB_LOAD;
          end
        end
      end
      ARB_HOLD: begin
        if (t_q == '0) begin
          ss_n_d      = '1;
          gnt_d       = '0;
          sess_done_d = 1'b1;
          last_d      = gidx_q;
          state_d     = ARB_GAP;
        end else begin
          t_d = t_q - 1'b1;
        end
      end
      ARB_GAP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // last_q resets to the top slot so requester 0 is next in line.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ARB_IDLE;
      t_q         <= '0;
      cnt_q       <= '0;
      gidx_q      <= '0;
      last_q      <= LW'(NREQ - 1);
      gnt_q       <= '0;
      ss_n_q      <= '1;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      sess_done_q <= 1'b0;
      eng_start_q <= 1'b0;
      eng_tx_q    <= '0;
      eng_mode_q  <= SPI_MODE0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      cnt_q       <= cnt_d;
      gidx_q      <= gidx_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      ss_n_q      <= ss_n_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      sess_done_q <= sess_done_d;
      eng_start_q <= eng_start_d;
      eng_tx_q    <= eng_tx_d;
      eng_mode_q  <= eng_mode_d;
    end
  end

  assign GNT        = gnt_q;
  assign SS_N       = ss_n_q;
  assign TX_READY   = tx_ready_q;
  assign RX_DATA    = rx_data_q;
  assign RX_VALID   = rx_valid_q;
  assign SESS_DONE  = sess_done_q;
  assign ENG_START  = eng_start_q;
  assign ENG_TXBYTE = eng_tx_q;
  assign ENG_MODE   = eng_mode_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a simple
// byte-engine model (RX byte = TX byte ^ 8'hA5).
module tb_spi_xfer_arbiter;

  localparam int NREQ      = 4;
  localparam int NSS       = 4;
  localparam int SETUP_CYC = 2;
  localparam int HOLD_CYC  = 2;
  localparam int ENG_LAT   = 8;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [3:0]      REQ = '0;
  logic [31:0]     REQ_LEN = '0;
  logic [7:0]      REQ_SS = '0;
  logic [7:0]      REQ_MODE = '0;
  logic [3:0]      GNT;
  logic [7:0]      TX_DATA;
  logic            TX_VALID;
  logic            TX_READY;
  logic [7:0]      RX_DATA;
  logic            RX_VALID;
  logic            SESS_DONE;
  logic            ENG_START;
  logic [7:0]      ENG_TXBYTE;
  logic [1:0]      ENG_MODE;
  logic            ENG_DONE;
  logic [7:0]      ENG_RXBYTE;
  logic [3:0]      SS_N;

  logic       tx_en = 1'b0;
  logic       stray_done = 1'b0;
  logic       eng_done_m = 1'b0;
  logic [7:0] eng_rx_m = '0;
  logic [7:0] eng_byte = '0;
  int         eng_cd = 0;
  int         tx_seq = 0;

  int n_cmp = 0;
  int n_err = 0;

  spi_xfer_arbiter #(
    .NREQ      (NREQ),
    .NSS       (NSS),
    .SETUP_CYC (SETUP_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .REQ        (REQ),
    .REQ_LEN    (REQ_LEN),
    .REQ_SS     (REQ_SS),
    .REQ_MODE   (REQ_MODE),
    .GNT        (GNT),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .RX_DATA    (RX_DATA),
    .RX_VALID   (RX_VALID),
    .SESS_DONE  (SESS_DONE),
    .ENG_START  (ENG_START),
    .ENG_TXBYTE (ENG_TXBYTE),
    .ENG_MODE   (ENG_MODE),
    .ENG_DONE   (ENG_DONE),
    .ENG_RXBYTE (ENG_RXBYTE),
    .SS_N       (SS_N)
  );

  always #5 PCLK = ~PCLK;

  assign TX_VALID   = tx_en;
  assign TX_DATA    = 8'h10 + 8'(tx_seq);
  assign ENG_DONE   = eng_done_m | stray_done;
  assign ENG_RXBYTE = eng_rx_m;

  always @(posedge PCLK) begin
    if (!PRESET && TX_VALID && TX_READY) tx_seq <= tx_seq + 1;
  end

  // Engine model ignores PRESET so an in-flight byte can finish late.
  always @(posedge PCLK) begin
    eng_done_m <= 1'b0;
    if (ENG_START) begin
      eng_cd   <= ENG_LAT;
      eng_byte <= ENG_TXBYTE;
    end else if (eng_cd != 0) begin
      eng_cd <= eng_cd - 1;
      if (eng_cd == 1) begin
        eng_done_m <= 1'b1;
        eng_rx_m   <= eng_byte ^ 8'hA5;
      end
    end
  end

  int         cyc = 0;
  int         n_start = 0;
  int         n_rx = 0;
  int         n_sess = 0;
  int         n_ss_bad = 0;
  int         last_done_cyc = 0;
  int         sess_lat = 0;
  int         hi_run = 0;
  bit         seen_low = 1'b0;
  logic [3:0] prev_gnt = '0;
  logic [7:0] start_q[$];
  logic [7:0] rx_q[$];
  logic [3:0] gnt_log[$];
  logic [3:0] ss_log[$];
  int         gap_q[$];

  always @(negedge PCLK) begin
    cyc++;
    if (ENG_DONE) last_done_cyc = cyc;
    if (ENG_START) begin
      n_start++;
      start_q.push_back(ENG_TXBYTE);
    end
    if (RX_VALID) begin
      n_rx++;
      rx_q.push_back(RX_DATA);
    end
    if (SESS_DONE) begin
      n_sess++;
      sess_lat = cyc - last_done_cyc;
      if (SS_N !== 4'hF) n_ss_bad++;
    end
    if (GNT != 0 && prev_gnt == 0) begin
      gnt_log.push_back(GNT);
      ss_log.push_back(SS_N);
    end
    prev_gnt = GNT;
    if (SS_N == 4'hF) hi_run++;
    else begin
      if (seen_low && hi_run > 0) gap_q.push_back(hi_run);
      hi_run   = 0;
      seen_low = 1'b1;
    end
  end

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] len,
                         input logic [1:0] ss, input logic [1:0] mode);
    REQ_LEN[i*8 +: 8] = len;
    REQ_SS[i*2 +: 2]  = ss;
    REQ_MODE[i*2 +: 2] = mode;
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    repeat (3) tick();
    PRESET = 1'b0;
  endtask

  task automatic wait_gnt(input int budget, input string nm);
    int k = 0;
    while (GNT == 0 && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (GNT == 0) begin
      n_err++;
      $display("FAIL %s: GNT=0 after %0d cycles, want a grant", nm, budget);
    end
  endtask

  task automatic wait_sess(input int target, input int budget, input string nm);
    int k = 0;
    while (n_sess < target && k < budget) begin
      tick();
      k++;
    end
    n_cmp++;
    if (n_sess < target) begin
      n_err++;
      $display("FAIL %s: sessions=%0d, want %0d", nm, n_sess, target);
    end
  endtask

  // Index of the first wrong start or rx byte, -1 when all n match.
  function automatic int bytes_bad(input int s0, input int r0,
                                   input int seq0, input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      e = 8'h10 + 8'(seq0 + k);
      if (s0 + k >= start_q.size() || r0 + k >= rx_q.size()) return k;
      if (start_q[s0+k] !== e) return k;
      if (rx_q[r0+k] !== (e ^ 8'hA5)) return k;
    end
    return -1;
  endfunction

  task automatic test_reset();
    PRESET = 1'b1;
    REQ    = 4'hF;
    repeat (2) tick();
    n_cmp++;
    if (SS_N !== 4'hF) begin
      n_err++;
      $display("FAIL reset_ss: got %b want 1111", SS_N);
    end
    n_cmp++;
    if (GNT !== 4'h0) begin
      n_err++;
      $display("FAIL reset_gnt: got %b want 0000", GNT);
    end
    n_cmp++;
    if ({TX_READY, RX_VALID, SESS_DONE, ENG_START} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_pulses: got %b want 0000",
               {TX_READY, RX_VALID, SESS_DONE, ENG_START});
    end
    n_cmp++;
    if ({ENG_TXBYTE, RX_DATA, ENG_MODE} !== 18'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0",
               {ENG_TXBYTE, RX_DATA, ENG_MODE});
    end
    REQ    = 4'h0;
    PRESET = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (GNT !== 4'h0) begin
      n_err++;
      $display("FAIL idle_no_req: got GNT=%b want 0000", GNT);
    end
  endtask

  task automatic test_single();
    int s0 = n_start;
    int r0 = n_rx;
    int d0 = n_sess;
    int b0 = n_ss_bad;
    int seq0 = tx_seq;
    int bad;
    set_req(1, 8'd2, 2'd3, 2'd1);
    tx_en = 1'b1;
    REQ   = 4'b0010;
    tick();
    n_cmp++;
    if (GNT !== 4'b0010) begin
      n_err++;
      $display("FAIL single_gnt: got %b want 0010", GNT);
    end
    n_cmp++;
    if (SS_N !== 4'b0111) begin
      n_err++;
      $display("FAIL single_ss: got %b want 0111", SS_N);
    end
    n_cmp++;
    if (ENG_MODE !== 2'd1) begin
      n_err++;
      $display("FAIL single_mode: got %0d want 1", ENG_MODE);
    end
    REQ = 4'b0000;
    tick();
    n_cmp++;
    if (TX_READY !== 1'b0) begin
      n_err++;
      $display("FAIL setup_early: TX_READY=%b want 0", TX_READY);
    end
    tick();
    n_cmp++;
    if (TX_READY !== 1'b1) begin
      n_err++;
      $display("FAIL setup_ready: TX_READY=%b want 1", TX_READY);
    end
    wait_sess(d0 + 1, 200, "single_sess");
    repeat (5) tick();
    n_cmp++;
    if (n_start - s0 != 3 || n_rx - r0 != 3) begin
      n_err++;
      $display("FAIL single_count: starts=%0d rx=%0d want 3/3",
               n_start - s0, n_rx - r0);
    end
    bad = bytes_bad(s0, r0, seq0, 3);
    n_cmp++;
    if (bad != -1) begin
      n_err++;
      $display("FAIL single_bytes: first bad byte %0d, want none", bad);
    end
    n_cmp++;
    if (n_sess - d0 != 1 || n_ss_bad != b0) begin
      n_err++;
      $display("FAIL single_done: sess=%0d ss_bad=%0d want 1/0",
               n_sess - d0, n_ss_bad - b0);
    end
    n_cmp++;
    if (sess_lat != HOLD_CYC + 1) begin
      n_err++;
      $display("FAIL hold_lat: got %0d want %0d", sess_lat, HOLD_CYC + 1);
    end
  endtask

  task automatic test_fairness();
    int g0;
    int gs;
    int d0;
    int k = 0;
    logic [3:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 8'd0, 2'(i), 2'(i));
    g0 = gnt_log.size();
    d0 = n_sess;
    tx_en = 1'b1;
    REQ   = 4'hF;
    wait_gnt(20, "fair_first");
    gs = gap_q.size();
    while (gnt_log.size() < g0 + 5 && k < 400) begin
      tick();
      k++;
    end
    REQ = 4'h0;
    wait_sess(d0 + 5, 200, "fair_sess");
    for (int i = 0; i < 5; i++) begin
      e = 4'b0001 << (i % 4);
      n_cmp++;
      if (gnt_log.size() <= g0 + i || gnt_log[g0+i] !== e) begin
        n_err++;
        $display("FAIL fair_order%0d: got %b want %b", i,
                 (gnt_log.size() > g0 + i) ? gnt_log[g0+i] : 4'h0, e);
      end
      n_cmp++;
      if (ss_log.size() <= g0 + i || ss_log[g0+i] !== ~e) begin
        n_err++;
        $display("FAIL fair_ss%0d: got %b want %b", i,
                 (ss_log.size() > g0 + i) ? ss_log[g0+i] : 4'h0, ~e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (gap_q.size() <= gs + i || gap_q[gs+i] < 2) begin
        n_err++;
        $display("FAIL fair_gap%0d: got %0d want >=2", i,
                 (gap_q.size() > gs + i) ? gap_q[gs+i] : 0);
      end
    end
  endtask

  task automatic test_tx_stall();
    int s0 = n_start;
    int r0 = n_rx;
    int d0 = n_sess;
    int seq0 = tx_seq;
    int k = 0;
    int hi = 0;
    int bad;
    set_req(2, 8'd2, 2'd1, 2'd0);
    tx_en = 1'b1;
    REQ   = 4'b0100;
    wait_gnt(20, "stall_gnt");
    REQ = 4'b0000;
    while (n_start < s0 + 1 && k < 50) begin
      tick();
      k++;
    end
    tx_en = 1'b0;
    repeat (30) begin
      tick();
      if (SS_N === 4'hF) hi++;
    end
    n_cmp++;
    if (hi != 0 || SS_N !== 4'b1101) begin
      n_err++;
      $display("FAIL stall_ss: high=%0d SS_N=%b want 0/1101", hi, SS_N);
    end
    n_cmp++;
    if (n_start - s0 != 1) begin
      n_err++;
      $display("FAIL stall_start: got %0d want 1", n_start - s0);
    end
    n_cmp++;
    if (TX_READY !== 1'b1 || GNT !== 4'b0100) begin
      n_err++;
      $display("FAIL stall_wait: TX_READY=%b GNT=%b want 1/0100",
               TX_READY, GNT);
    end
    tx_en = 1'b1;
    wait_sess(d0 + 1, 200, "stall_sess");
    bad = bytes_bad(s0, r0, seq0, 3);
    n_cmp++;
    if (bad != -1 || n_start - s0 != 3) begin
      n_err++;
      $display("FAIL stall_bytes: bad=%0d starts=%0d want -1/3",
               bad, n_start - s0);
    end
  endtask

  task automatic test_len_bounds();
    int s0 = n_start;
    int r0 = n_rx;
    int d0 = n_sess;
    int seq0 = tx_seq;
    int bad;
    set_req(3, 8'd0, 2'd2, 2'd2);
    tx_en = 1'b1;
    REQ   = 4'b1000;
    wait_gnt(20, "len0_gnt");
    REQ = 4'b0000;
    wait_sess(d0 + 1, 100, "len0_sess");
    repeat (3) tick();
    n_cmp++;
    if (n_start - s0 != 1 || n_rx - r0 != 1) begin
      n_err++;
      $display("FAIL len0_count: starts=%0d rx=%0d want 1/1",
               n_start - s0, n_rx - r0);
    end
    s0 = n_start;
    r0 = n_rx;
    d0 = n_sess;
    seq0 = tx_seq;
    set_req(0, 8'd255, 2'd0, 2'd3);
    REQ = 4'b0001;
    wait_gnt(20, "len255_gnt");
    n_cmp++;
    if (ENG_MODE !== 2'd3 || SS_N !== 4'b1110) begin
      n_err++;
      $display("FAIL len255_grant: mode=%0d SS_N=%b want 3/1110",
               ENG_MODE, SS_N);
    end
    REQ = 4'b0000;
    wait_sess(d0 + 1, 4000, "len255_sess");
    repeat (3) tick();
    n_cmp++;
    if (n_start - s0 != 256 || n_rx - r0 != 256) begin
      n_err++;
      $display("FAIL len255_count: starts=%0d rx=%0d want 256/256",
               n_start - s0, n_rx - r0);
    end
    bad = bytes_bad(s0, r0, seq0, 256);
    n_cmp++;
    if (bad != -1) begin
      n_err++;
      $display("FAIL len255_bytes: first bad byte %0d, want none", bad);
    end
  endtask

  task automatic test_mid_reset();
    int s0 = n_start;
    int r0;
    int d0;
    int k = 0;
    set_req(0, 8'd3, 2'd1, 2'd0);
    tx_en = 1'b1;
    REQ   = 4'b0001;
    wait_gnt(20, "mid_gnt");
    REQ = 4'b0000;
    while (n_start < s0 + 2 && k < 100) begin
      tick();
      k++;
    end
    PRESET = 1'b1;
    tick();
    n_cmp++;
    if (SS_N !== 4'hF || GNT !== 4'h0) begin
      n_err++;
      $display("FAIL mid_reset: SS_N=%b GNT=%b want 1111/0000", SS_N, GNT);
    end
    n_cmp++;
    if ({TX_READY, ENG_START, RX_VALID, SESS_DONE} !== 4'b0) begin
      n_err++;
      $display("FAIL mid_pulses: got %b want 0000",
               {TX_READY, ENG_START, RX_VALID, SESS_DONE});
    end
    PRESET = 1'b0;
    r0 = n_rx;
    repeat (15) tick();
    n_cmp++;
    if (n_rx != r0 || GNT !== 4'h0) begin
      n_err++;
      $display("FAIL late_done: rx=%0d GNT=%b want 0/0000", n_rx - r0, GNT);
    end
    for (int i = 0; i < 4; i++) set_req(i, 8'd0, 2'd0, 2'd0);
    d0  = n_sess;
    REQ = 4'hF;
    wait_gnt(20, "post_reset_gnt");
    n_cmp++;
    if (GNT !== 4'b0001) begin
      n_err++;
      $display("FAIL post_reset_prio: got %b want 0001", GNT);
    end
    REQ = 4'h0;
    wait_sess(d0 + 1, 100, "post_reset_sess");
  endtask

  task automatic test_spurious();
    int s0 = n_start;
    int r0 = n_rx;
    int d0 = n_sess;
    int seq0 = tx_seq;
    int k = 0;
    int bad;
    set_req(2, 8'd3, 2'd3, 2'd1);
    tx_en = 1'b1;
    REQ   = 4'b0100;
    wait_gnt(20, "spur_gnt");
    while (n_start < s0 + 1 && k < 50) begin
      tick();
      k++;
    end
    REQ   = 4'b0000;
    tx_en = 1'b0;
    k = 0;
    while (TX_READY !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (TX_READY !== 1'b1 || n_rx - r0 != 1) begin
      n_err++;
      $display("FAIL stray_load: TX_READY=%b rx=%0d want 1/1",
               TX_READY, n_rx - r0);
    end
    stray_done = 1'b1;
    tx_en      = 1'b1;
    tick();
    stray_done = 1'b0;
    wait_sess(d0 + 1, 200, "spur_sess");
    repeat (3) tick();
    n_cmp++;
    if (n_start - s0 != 4 || n_rx - r0 != 4 || n_sess - d0 != 1) begin
      n_err++;
      $display("FAIL spur_count: starts=%0d rx=%0d sess=%0d want 4/4/1",
               n_start - s0, n_rx - r0, n_sess - d0);
    end
    bad = bytes_bad(s0, r0, seq0, 4);
    n_cmp++;
    if (bad != -1) begin
      n_err++;
      $display("FAIL spur_bytes: first bad byte %0d, want none", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_tx_stall();
    test_len_bounds();
    test_mid_reset();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
